// File: rtl/srio_type9_unpack_pkg.sv
// Shared definitions for the SRIO type-9 unpacker: header layout, FSM encodings
// and small TKEEP helpers.
package srio_type9_unpack_pkg;

   localparam logic [3:0] FTYPE_DATASTREAM = 4'h9;

   // Header beat layout, big-endian
   localparam int HDR_COS_LSB   = 56;
   localparam int HDR_COS_W     = 8;
   localparam int HDR_FTYPE_LSB = 52;
   localparam int HDR_FTYPE_W   = 4;
   localparam int HDR_LEN_LSB   = 32;
   localparam int HDR_LEN_W     = 16;
   localparam int HDR_SID_LSB   = 16;
   localparam int HDR_SID_W     = 16;

   localparam logic [1:0] ST_HDR  = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   function automatic logic [3:0] keep_ones(input logic [7:0] keep);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
      return n;
   endfunction

   function automatic logic keep_contig(input logic [7:0] keep);
      case (keep)
         8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80: return 1'b1;
         default:                                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/srio_type9_unpack_stats.sv
// Saturating statistics counter bank for the type-9 unpacker; instanced only when
// SRIO_TYPE9_UNPACK_STATS_EN is defined.
module srio_type9_unpack_stats #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pkt_inc,
   input  logic             drop_inc,
   input  logic             err_inc,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (pkt_inc  && (pkt_cnt  != '1)) pkt_cnt  <= pkt_cnt  + 1'b1;
         if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
         if (err_inc  && (err_cnt  != '1)) err_cnt  <= err_cnt  + 1'b1;
      end
   end

endmodule

// File: rtl/srio_type9_unpack.sv
// SRIO type-9 receive unpacker: filters on the header beat, strips it and forwards
// payload through one register stage. Statistics exist only with SRIO_TYPE9_UNPACK_STATS_EN.
module srio_type9_unpack
   import srio_type9_unpack_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             AXIS_ACLK,
   input  logic             AXIS_ARESETN,
   input  logic             S_AXIS_TVALID,
   output logic             S_AXIS_TREADY,
   input  logic [63:0]      S_AXIS_TDATA,
   input  logic [7:0]       S_AXIS_TKEEP,
   input  logic             S_AXIS_TLAST,
   input  logic [31:0]      S_AXIS_TUSER,
   output logic             M_AXIS_TVALID,
   input  logic             M_AXIS_TREADY,
   output logic [63:0]      M_AXIS_TDATA,
   output logic [7:0]       M_AXIS_TKEEP,
   output logic             M_AXIS_TLAST,
   output logic [31:0]      M_AXIS_TUSER,
   input  logic             cfg_enable,
   input  logic             cfg_match_en,
   input  logic [15:0]      cfg_stream_id,
   output logic             hdr_vld,
   output logic [15:0]      hdr_stream_id,
   output logic [15:0]      hdr_length,
   output logic [7:0]       hdr_cos,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   logic [1:0]  state;
   logic [31:0] tuser_cap;
   logic        hdr_fire;
   logic        accept;
   logic        data_fire;
   logic [3:0]  hdr_ftype;
   logic [15:0] hdr_sid_in;

   assign hdr_ftype  = S_AXIS_TDATA[HDR_FTYPE_LSB +: HDR_FTYPE_W];
   assign hdr_sid_in = S_AXIS_TDATA[HDR_SID_LSB +: HDR_SID_W];

   assign hdr_fire  = (state == ST_HDR) && S_AXIS_TVALID;
   assign accept    = cfg_enable && (hdr_ftype == FTYPE_DATASTREAM) &&
                      (!cfg_match_en || (hdr_sid_in == cfg_stream_id));
   assign S_AXIS_TREADY = (state == ST_DATA) ? (!M_AXIS_TVALID || M_AXIS_TREADY) : 1'b1;
   assign data_fire = (state == ST_DATA) && S_AXIS_TVALID && S_AXIS_TREADY;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state         <= ST_HDR;
         hdr_vld       <= 1'b0;
         hdr_stream_id <= '0;
         hdr_length    <= '0;
         hdr_cos       <= '0;
         tuser_cap     <= '0;
      end else begin
         hdr_vld <= 1'b0;
         case (state)
            ST_HDR: begin
               // Header-only packets carry nothing to forward and leave the FSM in HDR
               if (hdr_fire && !S_AXIS_TLAST) begin
                  if (accept) begin
                     state         <= ST_DATA;
                     hdr_vld       <= 1'b1;
                     hdr_stream_id <= hdr_sid_in;
                     hdr_length    <= S_AXIS_TDATA[HDR_LEN_LSB +: HDR_LEN_W];
                     hdr_cos       <= S_AXIS_TDATA[HDR_COS_LSB +: HDR_COS_W];
                     tuser_cap     <= S_AXIS_TUSER;
                  end else begin
                     state <= ST_DROP;
                  end
               end
            end
            ST_DATA: if (data_fire && S_AXIS_TLAST) state <= ST_HDR;
            ST_DROP: if (S_AXIS_TVALID && S_AXIS_TLAST) state <= ST_HDR;
            default: state <= ST_HDR;
         endcase
      end
   end

   // TUSER travels with each beat so a new header cannot disturb a stalled last beat
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TKEEP  <= '0;
         M_AXIS_TLAST  <= 1'b0;
         M_AXIS_TUSER  <= '0;
      end else if (data_fire) begin
         M_AXIS_TVALID <= 1'b1;
         M_AXIS_TDATA  <= S_AXIS_TDATA;
         M_AXIS_TKEEP  <= S_AXIS_TKEEP;
         M_AXIS_TLAST  <= S_AXIS_TLAST;
         M_AXIS_TUSER  <= tuser_cap;
      end else if (M_AXIS_TREADY) begin
         M_AXIS_TVALID <= 1'b0;
      end
   end

`ifdef SRIO_TYPE9_UNPACK_STATS_EN
   logic [16:0] byte_cnt;
   logic [16:0] byte_sum;
   logic        keep_bad;
   logic        len_err;
   logic        pkt_inc;
   logic        drop_inc;
   logic        err_inc;

   assign byte_sum = byte_cnt + {13'd0, keep_ones(S_AXIS_TKEEP)};

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         byte_cnt <= '0;
         keep_bad <= 1'b0;
      end else if (hdr_fire) begin
         byte_cnt <= '0;
         keep_bad <= 1'b0;
      end else if (data_fire) begin
         byte_cnt <= byte_sum;
         keep_bad <= keep_bad || !keep_contig(S_AXIS_TKEEP);
      end
   end

   assign len_err  = (byte_sum != {1'b0, hdr_length}) || keep_bad || !keep_contig(S_AXIS_TKEEP);
   assign pkt_inc  = data_fire && S_AXIS_TLAST;
   assign drop_inc = hdr_fire && !accept;
   assign err_inc  = (hdr_fire && S_AXIS_TLAST) || (pkt_inc && len_err);

   srio_type9_unpack_stats #(.CNT_W(CNT_W)) u_stats (
      .clk      (AXIS_ACLK),
      .rst_n    (AXIS_ARESETN),
      .pkt_inc  (pkt_inc),
      .drop_inc (drop_inc),
      .err_inc  (err_inc),
      .pkt_cnt  (pkt_cnt),
      .drop_cnt (drop_cnt),
      .err_cnt  (err_cnt)
   );
`else
   assign pkt_cnt  = '0;
   assign drop_cnt = '0;
   assign err_cnt  = '0;
`endif

endmodule
